// File: rtl/trace_chk_pkg.sv
// Shared types and defaults for the dual-core trace lockstep checker.
package trace_chk_pkg;

    localparam int TRACE_W_DEF = 36;
    localparam int DEPTH_DEF   = 16;
    localparam int PTR_W       = $clog2(DEPTH_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        FAIL = 2'd3
    } state_e;

endpackage

// File: rtl/trace_fifo.sv
// Single-clock FIFO with extra-MSB pointers; a push to a full FIFO is only
// accepted when the same cycle also pops.
module trace_fifo
    import trace_chk_pkg::*;
#(
    parameter int W     = TRACE_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_q, wr_d;
    logic [AW:0]  rd_q, rd_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push_s;
    logic         do_pop_s;

    assign empty     = (wr_q == rd_q);
    assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign rdata     = mem_q[rd_q[AW-1:0]];

    // Pointer next-state.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push_s) begin
            wr_d = wr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_d = wr_q;
        end
        if (do_pop_s) begin
            rd_d = rd_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_d = rd_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q <= {(AW+1){1'b0}};
            rd_q <= {(AW+1){1'b0}};
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage array; contents are meaningless while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/trace_lockstep_checker.sv
// Buffers baseline/optimised retire traces, compares them pairwise and
// reports the first divergence, FIFO overflow, skew timeout or clean completion.
module trace_lockstep_checker
    import trace_chk_pkg::*;
#(
    parameter int TRACE_W  = TRACE_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int MAX_SKEW = 1024
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               enable,
    input  logic               a_valid,
    input  logic [TRACE_W-1:0] a_data,
    input  logic               a_trap,
    input  logic               b_valid,
    input  logic [TRACE_W-1:0] b_data,
    input  logic               b_trap,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               mismatch,
    output logic               overflow,
    output logic               timeout,
    output logic [31:0]        fail_idx,
    output logic [TRACE_W-1:0] fail_a,
    output logic [TRACE_W-1:0] fail_b,
    output logic [31:0]        match_count
);

    state_e             state_q, state_d;
    logic               a_full_s, a_empty_s, b_full_s, b_empty_s;
    logic [TRACE_W-1:0] a_head_s, b_head_s;
    logic               run_s, push_a_s, push_b_s, pop_s;
    logic               pend_mis_s, mis_s, ovf_s, tmo_s, fin_s, one_side_s;

    logic               cmp_vld_q, cmp_vld_d;
    logic               cmp_eq_q, cmp_eq_d;
    logic [TRACE_W-1:0] cmp_a_q, cmp_a_d, cmp_b_q, cmp_b_d;
    logic [31:0]        skew_q, skew_d;
    logic               trap_a_q, trap_a_d, trap_b_q, trap_b_d;
    logic               mis_q, mis_d, ovf_q, ovf_d, tmo_q, tmo_d;
    logic [31:0]        fail_idx_q, fail_idx_d, match_q, match_d;
    logic [TRACE_W-1:0] fail_a_q, fail_a_d, fail_b_q, fail_b_d;

    trace_fifo #(.W(TRACE_W), .DEPTH(DEPTH)) u_fifo_a (
        .clk(clk), .resetn(resetn), .push(push_a_s), .pop(pop_s),
        .wdata(a_data), .rdata(a_head_s), .full(a_full_s), .empty(a_empty_s)
    );

    trace_fifo #(.W(TRACE_W), .DEPTH(DEPTH)) u_fifo_b (
        .clk(clk), .resetn(resetn), .push(push_b_s), .pop(pop_s),
        .wdata(b_data), .rdata(b_head_s), .full(b_full_s), .empty(b_empty_s)
    );

    // A registered unequal pair blocks further pops before FAIL is reached.
    assign run_s      = (state_q == RUN);
    assign pend_mis_s = cmp_vld_q && !cmp_eq_q;
    assign push_a_s   = run_s && a_valid;
    assign push_b_s   = run_s && b_valid;
    assign pop_s      = run_s && !a_empty_s && !b_empty_s && !pend_mis_s;
    assign one_side_s = a_empty_s ^ b_empty_s;
    assign mis_s      = run_s && pend_mis_s;
    assign ovf_s      = (push_a_s && a_full_s && !pop_s) || (push_b_s && b_full_s && !pop_s);
    assign tmo_s      = run_s && one_side_s && (skew_q == 32'(MAX_SKEW - 1));
    assign fin_s      = run_s && trap_a_q && trap_b_q && a_empty_s && b_empty_s
                        && !cmp_vld_q && !a_valid && !b_valid;

    // Next-state logic of the checker FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable) state_d = RUN;
                else        state_d = IDLE;
            end
            RUN: begin
                if (mis_s || ovf_s || tmo_s) state_d = FAIL;
                else if (fin_s)              state_d = DONE;
                else                         state_d = RUN;
            end
            DONE:    state_d = DONE;
            FAIL:    state_d = FAIL;
            default: state_d = IDLE;
        endcase
    end

    // Compare pipeline, skew counter, trap latches and sticky result flags.
    always_comb begin
        cmp_vld_d  = pop_s;
        cmp_eq_d   = cmp_eq_q;
        cmp_a_d    = cmp_a_q;
        cmp_b_d    = cmp_b_q;
        skew_d     = skew_q;
        trap_a_d   = trap_a_q | (run_s & a_trap);
        trap_b_d   = trap_b_q | (run_s & b_trap);
        mis_d      = mis_q | mis_s;
        ovf_d      = ovf_q | (run_s & ovf_s);
        tmo_d      = tmo_q | tmo_s;
        fail_idx_d = fail_idx_q;
        fail_a_d   = fail_a_q;
        fail_b_d   = fail_b_q;
        match_d    = match_q;
        if (pop_s) begin
            cmp_eq_d = (a_head_s == b_head_s);
            cmp_a_d  = a_head_s;
            cmp_b_d  = b_head_s;
        end else begin
            cmp_eq_d = cmp_eq_q;
        end
        if (!run_s) begin
            skew_d = skew_q;
        end else if (pop_s || (a_empty_s && b_empty_s)) begin
            skew_d = 32'd0;
        end else if (one_side_s) begin
            skew_d = skew_q + 32'd1;
        end else begin
            skew_d = skew_q;
        end
        if (run_s && cmp_vld_q && cmp_eq_q) begin
            match_d = match_q + 32'd1;
        end else begin
            match_d = match_q;
        end
        if (mis_s) begin
            fail_idx_d = match_q;
            fail_a_d   = cmp_a_q;
            fail_b_d   = cmp_b_q;
        end else begin
            fail_idx_d = fail_idx_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cmp_vld_q  <= 1'b0;
            cmp_eq_q   <= 1'b0;
            cmp_a_q    <= {TRACE_W{1'b0}};
            cmp_b_q    <= {TRACE_W{1'b0}};
            skew_q     <= 32'd0;
            trap_a_q   <= 1'b0;
            trap_b_q   <= 1'b0;
            mis_q      <= 1'b0;
            ovf_q      <= 1'b0;
            tmo_q      <= 1'b0;
            fail_idx_q <= 32'd0;
            fail_a_q   <= {TRACE_W{1'b0}};
            fail_b_q   <= {TRACE_W{1'b0}};
            match_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            cmp_vld_q  <= cmp_vld_d;
            cmp_eq_q   <= cmp_eq_d;
            cmp_a_q    <= cmp_a_d;
            cmp_b_q    <= cmp_b_d;
            skew_q     <= skew_d;
            trap_a_q   <= trap_a_d;
            trap_b_q   <= trap_b_d;
            mis_q      <= mis_d;
            ovf_q      <= ovf_d;
            tmo_q      <= tmo_d;
            fail_idx_q <= fail_idx_d;
            fail_a_q   <= fail_a_d;
            fail_b_q   <= fail_b_d;
            match_q    <= match_d;
        end
    end

    // Output decode from registered state and flags.
    always_comb begin
        busy        = (state_q == RUN);
        done        = (state_q == DONE) || (state_q == FAIL);
        pass        = (state_q == DONE);
        mismatch    = mis_q;
        overflow    = ovf_q;
        timeout     = tmo_q;
        fail_idx    = fail_idx_q;
        fail_a      = fail_a_q;
        fail_b      = fail_b_q;
        match_count = match_q;
    end

endmodule

// File: tb/tb_trace_lockstep_checker.sv
// Directed bench for trace_lockstep_checker: per-cycle vector table for the
// lockstep pass/mismatch runs plus hand sequences for the multi-cycle corners.
module tb_trace_lockstep_checker;

    localparam int TW = 36;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          enable = 1'b0;
    logic          a_valid = 1'b0, b_valid = 1'b0;
    logic [TW-1:0] a_data = '0, b_data = '0;
    logic          a_trap = 1'b0, b_trap = 1'b0;

    logic          busy, done, pass, mismatch, overflow, timeout;
    logic [31:0]   fail_idx, match_count;
    logic [TW-1:0] fail_a, fail_b;

    logic          s_busy, s_done, s_pass, s_mismatch, s_overflow, s_timeout;
    logic [31:0]   s_fail_idx, s_match_count;
    logic [TW-1:0] s_fail_a, s_fail_b;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    trace_lockstep_checker dut (
        .clk(clk), .resetn(resetn), .enable(enable),
        .a_valid(a_valid), .a_data(a_data), .a_trap(a_trap),
        .b_valid(b_valid), .b_data(b_data), .b_trap(b_trap),
        .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
        .overflow(overflow), .timeout(timeout), .fail_idx(fail_idx),
        .fail_a(fail_a), .fail_b(fail_b), .match_count(match_count)
    );

    trace_lockstep_checker #(.MAX_SKEW(8)) dut_s (
        .clk(clk), .resetn(resetn), .enable(enable),
        .a_valid(a_valid), .a_data(a_data), .a_trap(a_trap),
        .b_valid(b_valid), .b_data(b_data), .b_trap(b_trap),
        .busy(s_busy), .done(s_done), .pass(s_pass), .mismatch(s_mismatch),
        .overflow(s_overflow), .timeout(s_timeout), .fail_idx(s_fail_idx),
        .fail_a(s_fail_a), .fail_b(s_fail_b), .match_count(s_match_count)
    );

    typedef struct {
        logic          rst;
        logic          av;
        logic [TW-1:0] ad;
        logic          bv;
        logic [TW-1:0] bd;
        logic          trap;
        logic [31:0]   e_match;
        logic          e_done;
        logic          e_pass;
        logic          e_mis;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(logic rst, logic av, logic [TW-1:0] ad, logic bv,
                                logic [TW-1:0] bd, logic trap, logic [31:0] m,
                                logic d, logic p, logic mi);
        vec_t v;
        v.rst = rst; v.av = av; v.ad = ad; v.bv = bv; v.bd = bd; v.trap = trap;
        v.e_match = m; v.e_done = d; v.e_pass = p; v.e_mis = mi;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        a_valid = 1'b0; b_valid = 1'b0; a_trap = 1'b0; b_trap = 1'b0;
        a_data = '0; b_data = '0;
    endtask

    task automatic reset_enable();
        clr_in();
        enable = 1'b0;
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
        step();
        enable = 1'b1;
        step();
        enable = 1'b0;
    endtask

    initial begin
        // Lockstep pass: a leads with 1..5, b lags 3 cycles, then both trap.
        tbl[0]  = mk(1'b1, 1'b1, 36'h1, 1'b0, 36'h0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 1'b1, 36'h2, 1'b0, 36'h0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        tbl[2]  = mk(1'b0, 1'b1, 36'h3, 1'b0, 36'h0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        tbl[3]  = mk(1'b0, 1'b1, 36'h4, 1'b1, 36'h1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        tbl[4]  = mk(1'b0, 1'b1, 36'h5, 1'b1, 36'h2, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        tbl[5]  = mk(1'b0, 1'b0, 36'h0, 1'b1, 36'h3, 1'b0, 32'd1, 1'b0, 1'b0, 1'b0);
        tbl[6]  = mk(1'b0, 1'b0, 36'h0, 1'b1, 36'h4, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0);
        tbl[7]  = mk(1'b0, 1'b0, 36'h0, 1'b1, 36'h5, 1'b0, 32'd3, 1'b0, 1'b0, 1'b0);
        tbl[8]  = mk(1'b0, 1'b0, 36'h0, 1'b0, 36'h0, 1'b1, 32'd4, 1'b0, 1'b0, 1'b0);
        tbl[9]  = mk(1'b0, 1'b0, 36'h0, 1'b0, 36'h0, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0);
        tbl[10] = mk(1'b0, 1'b0, 36'h0, 1'b0, 36'h0, 1'b0, 32'd5, 1'b1, 1'b1, 1'b0);
        // Same run with the third b word corrupted to 0xAB.
        tbl[11] = mk(1'b1, 1'b1, 36'h1, 1'b0, 36'h0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        tbl[12] = mk(1'b0, 1'b1, 36'h2, 1'b0, 36'h0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        tbl[13] = mk(1'b0, 1'b1, 36'h3, 1'b0, 36'h0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        tbl[14] = mk(1'b0, 1'b1, 36'h4, 1'b1, 36'h1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        tbl[15] = mk(1'b0, 1'b1, 36'h5, 1'b1, 36'h2, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        tbl[16] = mk(1'b0, 1'b0, 36'h0, 1'b1, 36'hAB, 1'b0, 32'd1, 1'b0, 1'b0, 1'b0);
        tbl[17] = mk(1'b0, 1'b0, 36'h0, 1'b1, 36'h4, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0);
        tbl[18] = mk(1'b0, 1'b0, 36'h0, 1'b1, 36'h5, 1'b0, 32'd2, 1'b1, 1'b0, 1'b1);
        tbl[19] = mk(1'b0, 1'b0, 36'h0, 1'b0, 36'h0, 1'b1, 32'd2, 1'b1, 1'b0, 1'b1);

        // Reset state.
        step();
        step();
        chk("rst_flags", {58'd0, busy, done, pass, mismatch, overflow, timeout}, 64'd0);
        chk("rst_match", {32'd0, match_count}, 64'd0);
        chk("rst_fidx", {32'd0, fail_idx}, 64'd0);
        chk("rst_fa", {28'd0, fail_a}, 64'd0);
        chk("rst_fb", {28'd0, fail_b}, 64'd0);

        for (int i = 0; i < 20; i++) begin
            if (tbl[i].rst) begin
                reset_enable();
                chk($sformatf("row%0d_busy", i), {63'd0, busy}, 64'd1);
            end
            a_valid = tbl[i].av; a_data = tbl[i].ad;
            b_valid = tbl[i].bv; b_data = tbl[i].bd;
            a_trap  = tbl[i].trap; b_trap = tbl[i].trap;
            step();
            clr_in();
            chk($sformatf("row%0d", i), {29'd0, match_count, done, pass, mismatch},
                {29'd0, tbl[i].e_match, tbl[i].e_done, tbl[i].e_pass, tbl[i].e_mis});
        end
        chk("mis_fidx", {32'd0, fail_idx}, 64'd2);
        chk("mis_fa", {28'd0, fail_a}, 64'h3);
        chk("mis_fb", {28'd0, fail_b}, 64'hAB);
        chk("mis_busy", {63'd0, busy}, 64'd0);

        // Overflow: 17 pushes into A with B silent.
        reset_enable();
        for (int i = 0; i < 16; i++) begin
            a_valid = 1'b1; a_data = 36'h100 + 36'(i);
            step();
        end
        chk("ovf_16", {62'd0, overflow, done}, 64'd0);
        a_data = 36'h110;
        step();
        clr_in();
        chk("ovf_17", {60'd0, overflow, done, pass, timeout}, 64'b1100);

        // Timeout with MAX_SKEW=8 instance: one A word, B silent.
        reset_enable();
        a_valid = 1'b1; a_data = 36'h55;
        step();
        clr_in();
        for (int i = 0; i < 7; i++) step();
        chk("tmo_7", {62'd0, s_timeout, s_done}, 64'd0);
        step();
        chk("tmo_8", {61'd0, s_timeout, s_done, s_pass}, 64'b110);

        // Full A, then concurrent pop and push into the full FIFO.
        reset_enable();
        for (int i = 0; i < 16; i++) begin
            a_valid = 1'b1; a_data = 36'h200 + 36'(i);
            step();
        end
        a_valid = 1'b0;
        b_valid = 1'b1; b_data = 36'h200;
        step();
        a_valid = 1'b1; a_data = 36'h2FF;
        b_valid = 1'b1; b_data = 36'h201;
        step();
        clr_in();
        chk("full_push", {62'd0, overflow, busy}, 64'b01);
        step();
        chk("full_cmp1", {30'd0, match_count, mismatch, overflow}, {30'd0, 32'd1, 2'b00});
        for (int i = 2; i < 16; i++) begin
            b_valid = 1'b1; b_data = 36'h200 + 36'(i);
            step();
        end
        b_data = 36'h2FF;
        step();
        clr_in();
        step();
        step();
        step();
        chk("full_drain", {29'd0, match_count, mismatch, overflow, busy},
            {29'd0, 32'd17, 3'b001});

        // Asynchronous reset mid-run, then a fresh 3-pair run.
        reset_enable();
        a_valid = 1'b1; a_data = 36'h7; b_valid = 1'b1; b_data = 36'h7;
        step();
        b_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_data = 36'h40 + 36'(i);
            step();
        end
        clr_in();
        chk("pre_rst_match", {32'd0, match_count}, 64'd1);
        #3;
        resetn = 1'b0;
        #1;
        chk("async_rst", {27'd0, match_count, busy, done, pass, mismatch, overflow}, 64'd0);
        step();
        resetn = 1'b1;
        step();
        chk("idle_after_rst", {62'd0, busy, done}, 64'd0);
        enable = 1'b1;
        step();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_valid = 1'b1; a_data = 36'h30 + 36'(i);
            b_valid = 1'b1; b_data = 36'h30 + 36'(i);
            step();
        end
        clr_in();
        a_trap = 1'b1; b_trap = 1'b1;
        step();
        clr_in();
        for (int k = 0; k < 20 && !done; k++) step();
        chk("rerun_done", {61'd0, done, pass, mismatch}, 64'b110);
        chk("rerun_match", {32'd0, match_count}, 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

endmodule
